// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - opcode enum and status flag indices for the registered ALU
//
// Shared by top and top_alu_core.
//   opcode_e       : 4-bit opcode, 16 entries including the reserved OP_RSVD
//   FLAG_C/V/Z/N   : bit positions of the status flags in the overflow bus

package top_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_XNOR = 4'h6,
    OP_NOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_NEG  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_PASS = 4'hC,
    OP_INC  = 4'hD,
    OP_DEC  = 4'hE,
    OP_RSVD = 4'hF
  } opcode_e;

  localparam int FLAG_W = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/top_alu_core.sv
// rtl/top_alu_core.sv - combinational ALU datapath and status flag generation
//
// Purely combinational; no state.
//   a, b   : operands (b ignored by unary ops)
//   op     : opcode
//   result : next result value
//   flags  : next {C,V,Z,N}, present only when TOP_STATUS_FLAGS_EN is defined

module top_alu_core
  import top_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  opcode_e           op,
`ifdef TOP_STATUS_FLAGS_EN
  output logic [FLAG_W-1:0] flags,
`endif
  output logic [WIDTH-1:0]  result
);

  // The shared adder is one bit wider only when the carry/borrow is needed.
`ifdef TOP_STATUS_FLAGS_EN
  localparam int AW = WIDTH + 1;
`else
  localparam int AW = WIDTH;
`endif

  logic [WIDTH-1:0] arith_x;
  logic [WIDTH-1:0] arith_y;
  logic             arith_sub;
  logic [AW-1:0]    arith_w;

  // Operand steering for the single add/subtract unit: inc/dec use a
  // constant 1, negate is computed as 0 - a.
  always_comb begin
    arith_x   = a;
    arith_y   = b;
    arith_sub = 1'b0;
    case (op)
      OP_SUB:  arith_sub = 1'b1;
      OP_INC:  arith_y   = WIDTH'(1);
      OP_DEC: begin
        arith_y   = WIDTH'(1);
        arith_sub = 1'b1;
      end
      OP_NEG: begin
        arith_x   = '0;
        arith_y   = a;
        arith_sub = 1'b1;
      end
      default: ;
    endcase
    // The top bit of the widened difference is the borrow (unsigned x < y).
    arith_w = arith_sub ? (AW'(arith_x) - AW'(arith_y))
                        : (AW'(arith_x) + AW'(arith_y));
  end

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_SUB, OP_NEG,
      OP_INC, OP_DEC: result = arith_w[WIDTH-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_XNOR:        result = ~(a ^ b);
      OP_NOR:         result = ~(a | b);
      OP_NAND:        result = ~(a & b);
      OP_SHL:         result = {a[WIDTH-2:0], 1'b0};
      OP_SHR:         result = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_PASS:        result = a;
      default:        result = '0;
    endcase
  end

`ifdef TOP_STATUS_FLAGS_EN
  logic add_ovf;
  logic sub_ovf;

  // Signed overflow: for add, both operands share a sign the sum lacks; for
  // subtract, operand signs differ and the difference loses the sign of x.
  assign add_ovf = (arith_x[WIDTH-1] == arith_y[WIDTH-1]) &&
                   (arith_w[WIDTH-1] != arith_x[WIDTH-1]);
  assign sub_ovf = (arith_x[WIDTH-1] != arith_y[WIDTH-1]) &&
                   (arith_w[WIDTH-1] != arith_x[WIDTH-1]);

  always_comb begin
    flags = '0;
    case (op)
      OP_ADD, OP_INC: begin
        flags[FLAG_C] = arith_w[WIDTH];
        flags[FLAG_V] = add_ovf;
      end
      OP_SUB, OP_DEC: begin
        flags[FLAG_C] = arith_w[WIDTH];
        flags[FLAG_V] = sub_ovf;
      end
      OP_NEG:  flags[FLAG_V] = sub_ovf;
      OP_SHL:  flags[FLAG_C] = a[WIDTH-1];
      OP_SHR:  flags[FLAG_C] = a[0];
      default: ;
    endcase
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
  end
`endif

endmodule

// File: rtl/top.sv
// rtl/top.sv - enable-gated registered ALU with optional status flags
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears result and overflow
//   enable   : capture the current operation on this edge
//   a, b     : operands
//   select   : opcode (see top_pkg::opcode_e)
//   result   : registered result, one cycle latency
//   overflow : registered {C,V,Z,N}
// Macro TOP_STATUS_FLAGS_EN compiles in the flag logic; without it overflow
// is tied to 4'b0000.

module top
  import top_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       overflow
);

  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

`ifdef TOP_STATUS_FLAGS_EN
  logic [FLAG_W-1:0] core_flags;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;
`endif

  top_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .op     (opcode_e'(select)),
`ifdef TOP_STATUS_FLAGS_EN
    .flags  (core_flags),
`endif
    .result (core_result)
  );

  always_comb begin
    result_d = enable ? core_result : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef TOP_STATUS_FLAGS_EN
  always_comb begin
    flags_d = enable ? core_flags : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign overflow = flags_q;
`else
  assign overflow = 4'b0000;
`endif

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed self-checking bench for the registered ALU

module tb_top;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  select;
  logic [31:0] result;
  logic [3:0]  overflow;

  int checks;
  int errors;

  top #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .a        (a),
    .b        (b),
    .select   (select),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are only produced when the flag logic is compiled in.
  function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef TOP_STATUS_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] er, input logic [3:0] ef);
    logic [3:0] fe;
    fe = exp_flags(ef);
    checks++;
    assert (result === er) else begin
      errors++;
      $error("FAIL %s result: got %h expected %h", tag, result, er);
    end
    checks++;
    assert (overflow === fe) else begin
      errors++;
      $error("FAIL %s overflow: got %b expected %b", tag, overflow, fe);
    end
  endtask

  // Drive one operation, let one rising edge pass, settle 1 time unit after it.
  task automatic step(input logic en, input logic [3:0] sel,
                      input logic [31:0] av, input logic [31:0] bv);
    enable = en;
    select = sel;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    a      = '0;
    b      = '0;
    select = '0;
    #2;
    check("reset_async", 32'h0, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0, 4'b0000);
    rst_n = 1'b1;

    // Flags below are {C,V,Z,N}.
    step(1'b1, 4'h0, 32'h00000005, 32'h0000000A); check("add_basic",   32'h0000000F, 4'b0000);
    step(1'b1, 4'h0, 32'h7FFFFFFF, 32'h00000001); check("add_sovf",    32'h80000000, 4'b0101);
    step(1'b1, 4'h1, 32'h0000000F, 32'h00000007); check("sub_basic",   32'h00000008, 4'b0000);
    step(1'b1, 4'h0, 32'hFFFFFFFF, 32'h00000001); check("add_carry",   32'h00000000, 4'b1010);
    step(1'b1, 4'h1, 32'h00000003, 32'h00000005); check("sub_borrow",  32'hFFFFFFFE, 4'b1001);
    step(1'b1, 4'h1, 32'h80000000, 32'h00000001); check("sub_sovf",    32'h7FFFFFFF, 4'b0100);
    step(1'b1, 4'h9, 32'hFFFFFFFA, 32'h0);        check("neg",         32'h00000006, 4'b0000);
    step(1'b1, 4'h9, 32'h80000000, 32'h0);        check("neg_min",     32'h80000000, 4'b0101);
    step(1'b1, 4'hD, 32'hFFFFFFFE, 32'h0);        check("inc",         32'hFFFFFFFF, 4'b0001);
    step(1'b1, 4'hD, 32'h7FFFFFFF, 32'h0);        check("inc_sovf",    32'h80000000, 4'b0101);
    step(1'b1, 4'hD, 32'hFFFFFFFF, 32'h0);        check("inc_wrap",    32'h00000000, 4'b1010);
    step(1'b1, 4'hE, 32'h00000000, 32'h0);        check("dec_zero",    32'hFFFFFFFF, 4'b1001);
    step(1'b1, 4'hE, 32'h80000000, 32'h0);        check("dec_sovf",    32'h7FFFFFFF, 4'b0100);
    step(1'b1, 4'hB, 32'h80000000, 32'h0);        check("shr_sign",    32'hC0000000, 4'b0001);
    step(1'b1, 4'hB, 32'h00000003, 32'h0);        check("shr_carry",   32'h00000001, 4'b1000);
    step(1'b1, 4'hA, 32'h00000001, 32'h0);        check("shl",         32'h00000002, 4'b0000);
    step(1'b1, 4'hA, 32'h80000001, 32'h0);        check("shl_carry",   32'h00000002, 4'b1000);
    step(1'b1, 4'hC, 32'h12345678, 32'hFFFFFFFF); check("pass",        32'h12345678, 4'b0000);
    step(1'b1, 4'h2, 32'h00000008, 32'h00000003); check("and_zero",    32'h00000000, 4'b0010);
    step(1'b1, 4'h8, 32'h00000008, 32'h00000003); check("nand",        32'hFFFFFFFF, 4'b0001);
    step(1'b1, 4'h3, 32'hF0000000, 32'h00000001); check("or",          32'hF0000001, 4'b0001);
    step(1'b1, 4'h4, 32'h0F0F0F0F, 32'h00FF00FF); check("xor",         32'h0FF00FF0, 4'b0000);
    step(1'b1, 4'h5, 32'h0000FFFF, 32'h0);        check("not",         32'hFFFF0000, 4'b0001);
    step(1'b1, 4'h6, 32'h12345678, 32'h12345678); check("xnor",        32'hFFFFFFFF, 4'b0001);
    step(1'b1, 4'h7, 32'h0000FF00, 32'h00000F0F); check("nor",         32'hFFFF00F0, 4'b0001);
    step(1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF); check("reserved",    32'h00000000, 4'b0010);

    // Capture a known non-zero value, then hold with enable low.
    step(1'b1, 4'h0, 32'h7FFFFFFF, 32'h00000001); check("pre_hold",    32'h80000000, 4'b0101);
    step(1'b0, 4'h1, 32'h00000001, 32'h00000001); check("hold_1",      32'h80000000, 4'b0101);
    step(1'b0, 4'hF, 32'h00000000, 32'h00000000); check("hold_2",      32'h80000000, 4'b0101);

    // Reset pulse between edges with an operation pending: outputs clear
    // before any edge, and the pending operation is not applied.
    enable = 1'b1;
    select = 4'h0;
    a      = 32'h00000010;
    b      = 32'h00000020;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 32'h0, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_release", 32'h0, 4'b0000);

    // First capture after reset release.
    @(posedge clk);
    #1;
    check("first_capture", 32'h00000030, 4'b0000);

    step(1'b0, 4'h0, 32'h1, 32'h1);               check("hold_after",  32'h00000030, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
